clk_div_n: RTL
==============

CLK_DIV_N -- requirements
Module: clk_div_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, divisor width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 3, divisor after reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  the only clock; posedge and negedge both used.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  run request; sampled only at period boundary.
REQ-006 SHALL have port div_val  input  WIDTH  requested divisor N.
REQ-007 SHALL have port div_load  input  1  one-cycle strobe that captures div_val.
REQ-008 SHALL have port clk_out  output  1  divided clock, 50% duty for all N.
REQ-009 SHALL have port tick  output  1  one-clk-cycle pulse, once per output period.
REQ-010 SHALL have port busy  output  1  high while a period is in progress or en=1.
REQ-011 SHALL have port cfg_err  output  1  sticky flag for an illegal divisor load.

Function
REQ-012 SHALL hold active divisor cur_n, pending divisor pend_n with pend_vld, counter cnt (WIDTH bits), q_pos (posedge reg), q_neg (negedge reg), odd flag = cur_n[0].
REQ-013 SHALL treat cnt==cur_n-1 as the idle/boundary state; clk_out is low there.
REQ-014 SHALL, at posedge with cnt!=cur_n-1, advance cnt by 1 regardless of en.
REQ-015 SHALL, at posedge with cnt==cur_n-1: if en=1, wrap cnt to 0; if en=0, hold cnt (stopped).
REQ-016 SHALL, on a wrap with pend_vld=1, load cur_n<=pend_n and clear pend_vld in the same edge; the new N governs the period that starts at cnt=0.
REQ-017 SHALL register q_pos <= (cnt_next < H), H=ceil(N/2), N being the divisor in force for cnt_next.
REQ-018 SHALL register q_neg <= q_pos on every negedge clk.
REQ-019 SHALL drive clk_out = odd ? (q_pos AND q_neg) : q_pos; even N gives N/2 high, N/2 low; odd N gives N/2 high (rise on negedge) and N/2 low, in clk periods.
REQ-020 SHALL produce no runt or glitch pulse on start, stop, or divisor change; all three occur only at boundary with clk_out low.
REQ-021 SHALL assert tick (registered) for exactly the clk cycle in which cnt==0.
REQ-022 SHALL drive busy = (cnt!=cur_n-1) OR en.
REQ-023 SHALL, on div_load with div_val>=2, set pend_n<=div_val, pend_vld<=1, cfg_err<=0; a later load before the boundary overwrites (last wins).
REQ-024 SHALL, on div_load with div_val<2, ignore the value, leave pend_n/pend_vld unchanged, set cfg_err<=1.
REQ-025 SHALL, when div_load coincides with a wrap edge, apply the previous pending value at that wrap; the new value applies at the next boundary.
REQ-026 SHALL, when en deasserts mid-period, complete the current period and stop at cnt==cur_n-1 with clk_out=0.
REQ-027 SHALL produce a first clk_out rising edge on the posedge after en is sampled 1 in idle (even N) or on the following negedge (odd N).

Reset
REQ-028 SHALL, on rst=1, immediately force cnt=DEFAULT_DIV-1, cur_n=pend_n=DEFAULT_DIV, pend_vld=0, q_pos=q_neg=0, tick=0, cfg_err=0; clk_out=0 and busy=en.
REQ-029 SHALL, on reset assertion mid-period, drop clk_out to 0 asynchronously and discard any pending divisor.
REQ-030 SHALL resume, after rst release with en=1, from the idle state per REQ-027.

Verification
REQ-031 SHALL cover: reset, en=1, N=3 -> clk_out period 3 clk, high 1.5 clk; tick every 3rd cycle.
REQ-032 SHALL cover: div_load div_val=4 mid-period of N=3 -> current 3-cycle period completes, then 2 high/2 low; no short pulse.
REQ-033 SHALL cover: N=7 -> high 3.5 clk, low 3.5 clk; rising clk_out aligned to negedge.
REQ-034 SHALL cover: en=0 at cnt=1 of N=6 -> period finishes, clk_out held 0, busy=0, tick stops; en=1 -> restart at next edge.
REQ-035 SHALL cover: div_load div_val=1 -> cfg_err=1, divisor unchanged; then div_val=5 -> cfg_err=0, N=5 from next boundary.
REQ-036 SHALL cover: rst asserted while clk_out high (N=8) -> clk_out=0 without waiting for a clk edge; pending load lost; N=3 after release.

Source files
------------

// File: rtl/clk_div_n.sv
// ----------------------------------------------------------------------------
// clk_div_n
// Programmable integer clock divider with a 50% duty-cycle output for both
// even and odd divisors. A posedge counter decides the output level. A
// negedge copy of that level stretches the high phase by half a clk period
// when the divisor is odd.
//
// Ports
//   clk      : the only clock; both edges are used
//   rst      : asynchronous, active-high reset
//   en       : run request, acted on only at a period boundary
//   div_val  : requested divisor N (legal 2 .. 2^WIDTH-1)
//   div_load : one-cycle strobe capturing div_val as the pending divisor
//   clk_out  : divided clock
//   tick     : one-clk-cycle pulse during the first cycle of each period
//   busy     : high while a period is in progress or en is high
//   cfg_err  : sticky flag, set by a load of an illegal divisor (<2),
//              cleared by the next legal load
// ----------------------------------------------------------------------------
module clk_div_n #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] cur_n_reg;
    logic [WIDTH-1:0] n_next;
    logic [WIDTH-1:0] pend_n_reg;
    logic             pend_vld_reg;
    logic             q_pos_reg;
    logic             q_pos_next;
    logic             q_neg_reg;
    logic             tick_reg;
    logic             cfg_err_reg;

    logic [WIDTH-1:0] last_cnt;
    logic             at_end;
    logic             wrap;
    logic [WIDTH:0]   half_next;
    logic             load_ok;

    // cnt == cur_n-1 is both the last cycle of a period and the idle state.
    assign last_cnt = cur_n_reg - 1'b1;
    assign at_end   = (cnt_reg == last_cnt);
    assign wrap     = at_end && en;
    assign load_ok  = (div_val >= WIDTH'(2));

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        n_next   = cur_n_reg;
        if (at_end) begin
            cnt_next = en ? '0 : cnt_reg;
            // A pending divisor takes over exactly at the wrap, so the new
            // period starting at cnt=0 is already timed with the new N.
            if (wrap && pend_vld_reg) begin
                n_next = pend_n_reg;
            end
        end
    end

    // High for the first ceil(N/2) counts of the period that cnt_next belongs to.
    // Because N-1 >= ceil(N/2) for every legal N, the idle/boundary count always
    // yields a low level, which keeps start, stop and divisor changes glitch-free.
    assign half_next  = ({1'b0, n_next} + (WIDTH+1)'(1)) >> 1;
    assign q_pos_next = ({1'b0, cnt_next} < half_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= DEF_N - 1'b1;
            cur_n_reg    <= DEF_N;
            pend_n_reg   <= DEF_N;
            pend_vld_reg <= 1'b0;
            q_pos_reg    <= 1'b0;
            tick_reg     <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            cur_n_reg <= n_next;
            q_pos_reg <= q_pos_next;
            tick_reg  <= (cnt_next == '0);
            if (wrap) begin
                pend_vld_reg <= 1'b0;
            end
            // Placed after the wrap handling: a load on the wrap edge is
            // queued for the following boundary, while the wrap itself used
            // the value that was pending before this edge.
            if (div_load) begin
                if (load_ok) begin
                    pend_n_reg   <= div_val;
                    pend_vld_reg <= 1'b1;
                    cfg_err_reg  <= 1'b0;
                end else begin
                    cfg_err_reg  <= 1'b1;
                end
            end
        end
    end

    // Half-cycle delayed copy of the posedge level, used for odd divisors.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_neg_reg <= 1'b0;
        end else begin
            q_neg_reg <= q_pos_reg;
        end
    end

    // Odd N: rise is delayed to the negedge and fall stays on the posedge,
    // giving N/2 clk periods high and N/2 low. Both registers are reset
    // asynchronously, so clk_out drops to 0 as soon as rst rises.
    assign clk_out = cur_n_reg[0] ? (q_pos_reg & q_neg_reg) : q_pos_reg;
    assign tick    = tick_reg;
    assign busy    = !at_end || en;
    assign cfg_err = cfg_err_reg;

endmodule
